// File: rtl/simple_uart_pkg.sv
// Shared definitions for the simple_uart_tx block: register word indices,
// register bit positions and the serialiser state encoding.
package simple_uart_pkg;

  // Register indices are byte offsets >> 2, matching the decoded addr_i[9:2].
  localparam logic [7:0] REG_TXDATA     = 8'h00;
  localparam logic [7:0] REG_STATUS     = 8'h01;
  localparam logic [7:0] REG_CTRL       = 8'h02;
  localparam logic [7:0] REG_BAUD_DIV   = 8'h03;
  localparam logic [7:0] REG_INTR_STATE = 8'h04;

  localparam int unsigned CTRL_TX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned STATUS_FULL      = 0;
  localparam int unsigned STATUS_EMPTY     = 1;
  localparam int unsigned STATUS_IDLE      = 2;
  localparam int unsigned STATUS_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/simple_uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART serialiser.
// The caller guarantees no pop when empty and no push when full unless a pop coincides.
module simple_uart_tx_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PtrW'(1);
    if (pop_i)  rptr_d = rptr_q + PtrW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == LvlW'(Depth));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;

endmodule

// File: rtl/simple_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register decode, TX FIFO and
// serialiser FSM with a tx_done interrupt.
module simple_uart_tx
  import simple_uart_pkg::*;
#(
  parameter int unsigned FifoDepth     = 16,
  parameter logic [15:0] ClkDivDefault = 16'd868,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic                    tx_o,
  output logic                    intr_o
);

  localparam int unsigned LvlW = $clog2(FifoDepth) + 1;

  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [15:0]     baud_q, baud_d;
  logic            tx_done_q, tx_done_d;
  logic            intr_q, intr_d;
  logic            tx_q, tx_d;
  tx_state_e       state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     period_q, period_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [LvlW-1:0] fifo_level;
  logic            push_req, w1c, done_set, load;
  logic [31:0]     status;
  logic [7:0]      reg_idx;
  logic            unused_bits;

  assign reg_idx     = addr_i[9:2];
  assign unused_bits = ^{addr_i[AddressWidth-1:10], addr_i[1:0], be_i[3:1],
                         wdata_i[DataWidth-1:16]};

  simple_uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    status                               = '0;
    status[STATUS_FULL]                  = fifo_full;
    status[STATUS_EMPTY]                 = fifo_empty;
    status[STATUS_IDLE]                  = fifo_empty && (state_q == ST_IDLE);
    status[STATUS_LEVEL_LSB +: 8]        = 8'(fifo_level);
  end

  always_comb begin
    rvalid_d = req_i;
    rdata_d  = '0;
    err_d    = 1'b0;
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    push_req = 1'b0;
    w1c      = 1'b0;
    if (req_i) begin
      case (reg_idx)
        REG_TXDATA: begin
          push_req = we_i && be_i[0];
          // A same-cycle pop frees a slot, so fullness is judged after the pop.
          err_d    = push_req && fifo_full && !fifo_pop;
        end
        REG_STATUS: if (!we_i) rdata_d = status;
        REG_CTRL: begin
          if (we_i) ctrl_d  = wdata_i[1:0];
          else      rdata_d = {30'b0, ctrl_q};
        end
        REG_BAUD_DIV: begin
          if (we_i) baud_d  = (wdata_i[15:0] == 16'd0) ? 16'd1 : wdata_i[15:0];
          else      rdata_d = {16'b0, baud_q};
        end
        REG_INTR_STATE: begin
          if (we_i) w1c     = wdata_i[0];
          else      rdata_d = {31'b0, tx_done_q};
        end
        default: err_d = 1'b1;
      endcase
    end
    fifo_push = push_req && (!fifo_full || fifo_pop);
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    fifo_pop  = 1'b0;
    done_set  = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE: load = ctrl_q[CTRL_TX_EN] && !fifo_empty;
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d   = ST_DATA;
          cnt_d     = period_q - 16'd1;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = period_q - 16'd1;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (ctrl_q[CTRL_TX_EN] && !fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            done_set = fifo_empty;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The bit period is captured per frame so BAUD_DIV edits never stretch a frame in flight.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      period_d = baud_q;
      cnt_d    = baud_q - 16'd1;
      state_d  = ST_START;
    end
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    tx_done_d = tx_done_q;
    if (w1c)      tx_done_d = 1'b0;
    if (done_set) tx_done_d = 1'b1;
    intr_d = tx_done_q && ctrl_q[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ctrl_q    <= '0;
      baud_q    <= ClkDivDefault;
      tx_done_q <= 1'b0;
      intr_q    <= 1'b0;
      tx_q      <= 1'b1;
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ctrl_q    <= ctrl_d;
      baud_q    <= baud_d;
      tx_done_q <= tx_done_d;
      intr_q    <= intr_d;
      tx_q      <= tx_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign tx_o     = tx_q;
  assign intr_o   = intr_q;

endmodule

// File: tb/tb_simple_uart_tx.sv
// Directed bench for simple_uart_tx: register map, frame timing, FIFO limits,
// interrupt behaviour and asynchronous reset.
module tb_simple_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        rvalid, err, tx, intr;
  logic [31:0] rdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rd_v;
  logic        er_v;
  logic [7:0]  bytes_q [16];

  simple_uart_tx dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .we_i    (we),
    .be_i    (be),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err),
    .tx_o    (tx),
    .intr_o  (intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at a negedge; drives one request cycle and returns at the next negedge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] r, output logic e);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    r = rdata; e = err;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    bus(1'b0, a, 32'd0, 4'hF, r, e);
    chk(tag, r, exp);
    chk({tag, " err"}, {31'b0, e}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic e);
    logic [31:0] r;
    bus(1'b1, a, d, 4'hF, r, e);
  endtask

  // Entered at the negedge of the frame's first cycle; leaves one cycle past its end.
  task automatic watch_frame(input string tag, input logic [9:0] exp, input int bd);
    logic [9:0] obs;
    int         glitch;
    obs    = '0;
    glitch = 0;
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < bd; c++) begin
        if (c == 0) obs[j] = tx;
        else if (tx !== obs[j]) glitch++;
        @(negedge clk);
      end
    end
    chk({tag, " bits"}, {22'b0, obs}, {22'b0, exp});
    chk({tag, " width"}, 32'(glitch), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) bytes_q[i] = 8'(i * 17 + 3);
    repeat (2) @(negedge clk);
    chk("reset tx", {31'b0, tx}, 32'd1);
    chk("reset rvalid", {31'b0, rvalid}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset intr", {31'b0, intr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("status after reset", 32'h04, 32'h0000_0006);
    rd_chk("baud after reset", 32'h0C, 32'h0000_0364);

    // Single 0xA5 frame at 4 cycles per bit with interrupts enabled.
    wr(32'h0C, 32'd4, er_v);
    wr(32'h08, 32'h3, er_v);
    wr(32'h00, 32'hA5, er_v);
    chk("txdata err", {31'b0, er_v}, 32'd0);
    chk("tx idle cycle1", {31'b0, tx}, 32'd1);
    @(negedge clk);
    watch_frame("a5", 10'b1_1010_0101_0, 4);
    chk("tx after a5", {31'b0, tx}, 32'd1);
    chk("intr cycle42", {31'b0, intr}, 32'd0);
    @(negedge clk);
    chk("intr cycle43", {31'b0, intr}, 32'd1);
    rd_chk("intr_state set", 32'h10, 32'd1);
    wr(32'h10, 32'd1, er_v);
    chk("intr held one cycle", {31'b0, intr}, 32'd1);
    @(negedge clk);
    chk("intr cleared", {31'b0, intr}, 32'd0);
    rd_chk("intr_state cleared", 32'h10, 32'd0);

    // Fill the FIFO with the serialiser disabled, then overflow it.
    wr(32'h08, 32'h0, er_v);
    for (int i = 0; i < 16; i++) wr(32'h00, {24'b0, bytes_q[i]}, er_v);
    rd_chk("status full", 32'h04, 32'h0000_1001);
    wr(32'h00, 32'h99, er_v);
    chk("overflow err", {31'b0, er_v}, 32'd1);
    rd_chk("status still full", 32'h04, 32'h0000_1001);
    wr(32'h08, 32'h1, er_v);
    chk("tx idle before drain", {31'b0, tx}, 32'd1);
    wr(32'h00, 32'hE7, er_v);
    chk("push full with pop", {31'b0, er_v}, 32'd0);
    for (int i = 0; i < 16; i++)
      watch_frame($sformatf("frame%0d", i), {1'b1, bytes_q[i], 1'b0}, 4);
    watch_frame("frame e7", 10'b1_1110_0111_0, 4);
    chk("tx after drain", {31'b0, tx}, 32'd1);
    rd_chk("status drained", 32'h04, 32'h0000_0006);
    rd_chk("done without irq_en", 32'h10, 32'd1);
    chk("intr masked", {31'b0, intr}, 32'd0);
    wr(32'h10, 32'd1, er_v);

    // Decode errors and byte-enable handling.
    wr(32'h08, 32'h0, er_v);
    bus(1'b0, 32'h14, 32'd0, 4'hF, rd_v, er_v);
    chk("read 0x14 err", {31'b0, er_v}, 32'd1);
    chk("read 0x14 rdata", rd_v, 32'd0);
    bus(1'b1, 32'h3FC, 32'hFFFF_FFFF, 4'hF, rd_v, er_v);
    chk("write 0x3fc err", {31'b0, er_v}, 32'd1);
    chk("write 0x3fc rdata", rd_v, 32'd0);
    rd_chk("ctrl unchanged", 32'h08, 32'd0);
    rd_chk("baud unchanged", 32'h0C, 32'd4);
    bus(1'b1, 32'h00, 32'h0000_0055, 4'b1110, rd_v, er_v);
    chk("be0 clear err", {31'b0, er_v}, 32'd0);
    rd_chk("be0 clear no push", 32'h04, 32'h0000_0006);
    rd_chk("txdata reads zero", 32'h00, 32'd0);
    wr(32'h08, 32'hFFFF_FFFF, er_v);
    rd_chk("ctrl masked bits", 32'h08, 32'h3);
    wr(32'h08, 32'h0, er_v);

    // Zero divisor clamps to 1; divisor change mid-frame applies to the next frame.
    wr(32'h0C, 32'd0, er_v);
    rd_chk("baud zero->1", 32'h0C, 32'd1);
    wr(32'h00, 32'h3C, er_v);
    wr(32'h00, 32'hC3, er_v);
    wr(32'h0C, 32'd2, er_v);
    wr(32'h08, 32'h1, er_v);
    chk("tx idle before baud2", {31'b0, tx}, 32'd1);
    @(negedge clk);
    fork
      begin
        watch_frame("baud2", 10'b1_0011_1100_0, 2);
        watch_frame("baud8", 10'b1_1100_0011_0, 8);
      end
      begin
        repeat (6) @(negedge clk);
        bus(1'b1, 32'h0C, 32'd8, 4'hF, rd_v, er_v);
      end
    join
    chk("tx after baud8", {31'b0, tx}, 32'd1);
    rd_chk("baud now 8", 32'h0C, 32'd8);

    // Asynchronous reset in the middle of a data bit.
    wr(32'h00, 32'h00, er_v);
    wr(32'h00, 32'h55, er_v);
    repeat (12) @(negedge clk);
    chk("tx low in data", {31'b0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("tx async reset", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("status after mid reset", 32'h04, 32'h0000_0006);
    rd_chk("ctrl after mid reset", 32'h08, 32'd0);
    rd_chk("baud after mid reset", 32'h0C, 32'h0000_0364);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
